// File: rtl/rf_pkg.sv
// Shared widths and requester-id encoding for the register-file write arbiter.
package rf_pkg;
    localparam int NUM_REGS   = 8;
    localparam int REG_ADDR_W = $clog2(NUM_REGS);
    localparam int DATA_W     = 8;
    localparam int NUM_REQ    = 2;

    // Also used as the grant-vector bit index.
    typedef enum logic {
        REQ_WB = 1'b0,
        REQ_LD = 1'b1
    } req_id_e;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// Requester, register-file write and forwarding signals of the write arbiter.
interface rf_write_arbiter_if;
    import rf_pkg::*;

    logic                  wb_valid;
    logic [REG_ADDR_W-1:0] wb_rd;
    logic [DATA_W-1:0]     wb_data;
    logic                  wb_ready;
    logic                  ld_valid;
    logic [REG_ADDR_W-1:0] ld_rd;
    logic [DATA_W-1:0]     ld_data;
    logic                  ld_ready;
    logic                  rf_writereg;
    logic [REG_ADDR_W-1:0] rf_rd;
    logic [DATA_W-1:0]     rf_writedata;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  fwd1_hit;
    logic                  fwd2_hit;
    logic [DATA_W-1:0]     fwd_data;

    modport master (
        output wb_valid, wb_rd, wb_data, ld_valid, ld_rd, ld_data, rs1, rs2,
        input  wb_ready, ld_ready, rf_writereg, rf_rd, rf_writedata,
               fwd1_hit, fwd2_hit, fwd_data
    );

    modport slave (
        input  wb_valid, wb_rd, wb_data, ld_valid, ld_rd, ld_data, rs1, rs2,
        output wb_ready, ld_ready, rf_writereg, rf_rd, rf_writedata,
               fwd1_hit, fwd2_hit, fwd_data
    );
endinterface

// File: rtl/rf_write_arbiter_grant.sv
// Combinational grant for the two write requesters (module rf_arb_grant).
// RF_ARB_ROUND_ROBIN_EN selects round-robin on last grant instead of fixed priority with starvation limit.
module rf_arb_grant
    import rf_pkg::*;
#(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = $clog2(STARVE_LIMIT + 1)
) (
    input  logic               en_i,
    input  logic               wb_valid_i,
    input  logic               ld_valid_i,
`ifdef RF_ARB_ROUND_ROBIN_EN
    input  req_id_e            last_grant_i,
`else
    input  logic [CNT_W-1:0]   starve_cnt_i,
`endif
    output logic [NUM_REQ-1:0] grant_o
);
    logic ld_wins;

    always_comb begin
        grant_o = '0;
        ld_wins = 1'b0;
        if (en_i) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
            ld_wins = ld_valid_i && (!wb_valid_i || (last_grant_i == REQ_WB));
`else
            ld_wins = ld_valid_i && (!wb_valid_i || (starve_cnt_i == CNT_W'(STARVE_LIMIT)));
`endif
            grant_o[REQ_LD] = ld_wins;
            grant_o[REQ_WB] = wb_valid_i && !ld_wins;
        end
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// Two-requester register-file write arbiter with registered write port and forwarding compare.
// RF_ARB_ROUND_ROBIN_EN selects round-robin arbitration; default is fixed priority with starvation limit.
module rf_write_arbiter
    import rf_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    rf_write_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    // Assertion is immediate; release lands one edge later so no grant races the reset edge.
    logic rst_sync_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) rst_sync_q <= 1'b0;
        else          rst_sync_q <= 1'b1;
    end

    logic [NUM_REQ-1:0] grant;

`ifdef RF_ARB_ROUND_ROBIN_EN
    req_id_e last_grant_q, last_grant_d;
`else
    logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
`endif

    rf_arb_grant #(
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) u_grant (
        .en_i         (rst_sync_q),
        .wb_valid_i   (bus.wb_valid),
        .ld_valid_i   (bus.ld_valid),
`ifdef RF_ARB_ROUND_ROBIN_EN
        .last_grant_i (last_grant_q),
`else
        .starve_cnt_i (starve_cnt_q),
`endif
        .grant_o      (grant)
    );

    assign bus.wb_ready = grant[REQ_WB];
    assign bus.ld_ready = grant[REQ_LD];

    logic                  wr_q, wr_d;
    logic [REG_ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0]     data_q, data_d;

    always_comb begin
        wr_d   = 1'b0;
        rd_d   = rd_q;
        data_d = data_q;
        if (grant[REQ_WB]) begin
            wr_d   = 1'b1;
            rd_d   = bus.wb_rd;
            data_d = bus.wb_data;
        end else if (grant[REQ_LD]) begin
            wr_d   = 1'b1;
            rd_d   = bus.ld_rd;
            data_d = bus.ld_data;
        end
    end

`ifdef RF_ARB_ROUND_ROBIN_EN
    always_comb begin
        last_grant_d = last_grant_q;
        if (grant[REQ_WB])      last_grant_d = REQ_WB;
        else if (grant[REQ_LD]) last_grant_d = REQ_LD;
    end

    always_ff @(posedge clk_i or negedge rst_sync_q) begin
        if (!rst_sync_q) last_grant_q <= REQ_WB;
        else             last_grant_q <= last_grant_d;
    end
`else
    always_comb begin
        starve_cnt_d = '0;
        if (bus.ld_valid && !grant[REQ_LD]) begin
            starve_cnt_d = (starve_cnt_q == CNT_W'(STARVE_LIMIT)) ? starve_cnt_q
                                                                   : starve_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_sync_q) begin
        if (!rst_sync_q) starve_cnt_q <= '0;
        else             starve_cnt_q <= starve_cnt_d;
    end
`endif

    always_ff @(posedge clk_i or negedge rst_sync_q) begin
        if (!rst_sync_q) begin
            wr_q   <= 1'b0;
            rd_q   <= '0;
            data_q <= '0;
        end else begin
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            data_q <= data_d;
        end
    end

    assign bus.rf_writereg  = wr_q;
    assign bus.rf_rd        = rd_q;
    assign bus.rf_writedata = data_q;
    assign bus.fwd1_hit     = wr_q && (rd_q == bus.rs1);
    assign bus.fwd2_hit     = wr_q && (rd_q == bus.rs2);
    assign bus.fwd_data     = data_q;
endmodule

// File: tb/tb_rf_write_arbiter.sv
// Directed plus randomized checks of rf_write_arbiter against a cycle-level reference model.
module tb_rf_write_arbiter;
    localparam int LIM = 4;

    logic clk;
    logic rst_n;
    rf_write_arbiter_if bus_if ();

    rf_write_arbiter #(.STARVE_LIMIT(LIM)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;

    // stimulus for the current cycle
    logic       in_wbv, in_ldv;
    logic [2:0] in_wbrd, in_ldrd, in_rs1, in_rs2;
    logic [7:0] in_wbd, in_ldd;
    logic       wb_pend, ld_pend;

    // reference model: pending register-file write plus arbitration history
    logic       m_wr;
    logic [2:0] m_rd;
    logic [7:0] m_data;
    int         m_wait;   // consecutive cycles ld has been refused
    logic       m_last;   // 1 when ld received the most recent grant

    logic obs_wb, obs_ld, obs_f1, obs_f2;
    logic [7:0] obs_fd;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_wr   = 1'b0;
        m_rd   = '0;
        m_data = '0;
        m_wait = 0;
        m_last = 1'b0;
    endtask

    task automatic drive();
        bus_if.wb_valid = in_wbv;
        bus_if.wb_rd    = in_wbrd;
        bus_if.wb_data  = in_wbd;
        bus_if.ld_valid = in_ldv;
        bus_if.ld_rd    = in_ldrd;
        bus_if.ld_data  = in_ldd;
        bus_if.rs1      = in_rs1;
        bus_if.rs2      = in_rs2;
    endtask

    // One clock cycle: drive at negedge, check, advance model, wait for next negedge.
    task automatic cycle();
        logic e_wb, e_ld;
        drive();
        #1;
        if (in_wbv && in_ldv) begin
`ifdef RF_ARB_ROUND_ROBIN_EN
            e_ld = !m_last;
`else
            e_ld = (m_wait >= LIM);
`endif
            e_wb = !e_ld;
        end else begin
            e_wb = in_wbv;
            e_ld = in_ldv;
        end
        obs_wb = bus_if.wb_ready;
        obs_ld = bus_if.ld_ready;
        obs_f1 = bus_if.fwd1_hit;
        obs_f2 = bus_if.fwd2_hit;
        obs_fd = bus_if.fwd_data;
        chk("wb_ready", obs_wb, e_wb);
        chk("ld_ready", obs_ld, e_ld);
        chk("rf_writereg", bus_if.rf_writereg, m_wr);
        chk("rf_rd", bus_if.rf_rd, m_rd);
        chk("rf_writedata", bus_if.rf_writedata, m_data);
        chk("fwd1_hit", obs_f1, m_wr && (m_rd == in_rs1));
        chk("fwd2_hit", obs_f2, m_wr && (m_rd == in_rs2));
        chk("fwd_data", obs_fd, m_data);
        if (e_wb) begin
            m_wr = 1'b1; m_rd = in_wbrd; m_data = in_wbd; m_last = 1'b0;
        end else if (e_ld) begin
            m_wr = 1'b1; m_rd = in_ldrd; m_data = in_ldd; m_last = 1'b1;
        end else begin
            m_wr = 1'b0;
        end
        if (in_ldv && !e_ld) m_wait = (m_wait < LIM) ? m_wait + 1 : LIM;
        else                 m_wait = 0;
        @(negedge clk);
    endtask

    task automatic gen(input int wb_pct, input int ld_pct);
        if (!wb_pend) begin
            wb_pend = ($urandom_range(0, 99) < wb_pct);
            in_wbrd = 3'($urandom);
            in_wbd  = 8'($urandom);
        end
        if (!ld_pend) begin
            ld_pend = ($urandom_range(0, 99) < ld_pct);
            in_ldrd = 3'($urandom);
            in_ldd  = 8'($urandom);
        end
        in_wbv = wb_pend;
        in_ldv = ld_pend;
        in_rs1 = 3'($urandom);
        in_rs2 = 3'($urandom);
    endtask

    task automatic rand_cycles(input int n);
        for (int k = 0; k < n; k++) begin
            gen(75, 55);
            cycle();
            if (obs_wb) wb_pend = 1'b0;
            if (obs_ld) ld_pend = 1'b0;
        end
    endtask

    initial begin
        model_reset();
        wb_pend = 1'b0; ld_pend = 1'b0;
        in_wbv = 1'b1; in_wbrd = 3'd1; in_wbd = 8'h11;
        in_ldv = 1'b1; in_ldrd = 3'd2; in_ldd = 8'h22;
        in_rs1 = 3'd0; in_rs2 = 3'd0;
        rst_n = 1'b0;
        drive();

        // reset: outputs cleared and no grants even with both requesters valid
        repeat (2) @(negedge clk);
        #1;
        chk("rst_wb_ready", bus_if.wb_ready, 1'b0);
        chk("rst_ld_ready", bus_if.ld_ready, 1'b0);
        chk("rst_writereg", bus_if.rf_writereg, 1'b0);
        chk("rst_rf_rd", bus_if.rf_rd, 3'd0);
        chk("rst_writedata", bus_if.rf_writedata, 8'd0);
        chk("rst_fwd1", bus_if.fwd1_hit, 1'b0);
        @(negedge clk);

        // release is synchronized: still no grant until the next rising edge
        rst_n = 1'b1;
        #1;
        chk("rel_wb_ready", bus_if.wb_ready, 1'b0);
        chk("rel_ld_ready", bus_if.ld_ready, 1'b0);
        in_wbv = 1'b0; in_ldv = 1'b0;
        drive();
        @(negedge clk);
        chk("rel_writereg", bus_if.rf_writereg, 1'b0);

        // both valid continuously from reset
        in_ldv = 1'b1; in_ldrd = 3'd6; in_ldd = 8'hC3;
        for (int i = 0; i < 6; i++) begin
            logic exp_ld;
            in_wbv = 1'b1; in_wbrd = 3'($urandom); in_wbd = 8'($urandom);
            cycle();
`ifdef RF_ARB_ROUND_ROBIN_EN
            exp_ld = (i % 2 == 0);
`else
            exp_ld = (i == LIM);
`endif
            chk("seq_ld_grant", obs_ld, exp_ld);
            chk("seq_wb_grant", obs_wb, !exp_ld);
        end
        in_wbv = 1'b0; in_ldv = 1'b0;
        cycle();

        // single wb request: same-cycle grant, write visible next cycle
        in_wbv = 1'b1; in_wbrd = 3'd3; in_wbd = 8'h5A;
        cycle();
        chk("t034_ready", obs_wb, 1'b1);
        chk("t034_writereg", bus_if.rf_writereg, 1'b1);
        chk("t034_rd", bus_if.rf_rd, 3'd3);
        chk("t034_data", bus_if.rf_writedata, 8'h5A);

        // forwarding hit on an in-flight write, then idle
        in_wbv = 1'b1; in_wbrd = 3'd5; in_wbd = 8'h77;
        cycle();
        in_wbv = 1'b0; in_rs1 = 3'd5; in_rs2 = 3'd2;
        cycle();
        chk("t037_fwd1", obs_f1, 1'b1);
        chk("t037_fwd2", obs_f2, 1'b0);
        chk("t037_fwd_data", obs_fd, 8'h77);
        cycle();
        chk("t037_idle_fwd1", obs_f1, 1'b0);
        chk("t037_idle_fwd2", obs_f2, 1'b0);

        rand_cycles(300);

        // reset mid-stream with a write sitting in the output register
        in_wbv = 1'b1; in_wbrd = 3'd4; in_wbd = 8'h99; in_ldv = 1'b0;
        cycle();
        in_ldv = 1'b1; in_ldrd = 3'd7; in_ldd = 8'h3C;
        wb_pend = 1'b1; ld_pend = 1'b1;
        drive();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_writereg", bus_if.rf_writereg, 1'b0);
        chk("mid_rst_rf_rd", bus_if.rf_rd, 3'd0);
        chk("mid_rst_wb_ready", bus_if.wb_ready, 1'b0);
        chk("mid_rst_ld_ready", bus_if.ld_ready, 1'b0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rel_wb_ready", bus_if.wb_ready, 1'b0);
        @(negedge clk);
        chk("mid_rel_writereg", bus_if.rf_writereg, 1'b0);

        rand_cycles(60);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
